// File: rtl/div16_ctrl.sv
// Sequencer for the 16-bit restoring divider: drives the external subtractor
// stage one bit per SHIFT/SUB pair and assembles quotient and remainder.
module div16_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             sub_msb,
  input  logic [WIDTH-1:0] sub_result,
  output logic [WIDTH-1:0] sub_a,
  output logic [WIDTH-1:0] sub_b,
  output logic             sub_dv0,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_zero
);

  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SUB   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   p_q, p_d;
  logic               ov_q, ov_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               dv0_q, dv0_d;
  logic               dz_q, dz_d;
  logic               accept;

  assign sub_a     = p_q;
  assign sub_b     = d_q;
  assign sub_dv0   = dv0_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign div_zero  = dz_q;

  // An overflowed partial remainder always exceeds the divisor, so it forces accept.
  assign accept = ~sub_msb | ov_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      ov_q    <= 1'b0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      dv0_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      ov_q    <= ov_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      dv0_q   <= dv0_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    ov_d    = ov_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          p_d   = '0;
          ov_d  = 1'b0;
          q_d   = dividend;
          d_d   = divisor;
          cnt_d = CNT_INIT;
          dz_d  = 1'b0;
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend;
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        ov_d    = p_q[WIDTH-1];
        p_d     = {p_q[WIDTH-2:0], q_q[WIDTH-1]};
        q_d     = {q_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = SUB;
      end
      SUB: begin
        if (accept) begin
          p_d = sub_result;
        end
        q_d[0] = accept;
        if (cnt_q == '0) begin
          quot_d  = {q_q[WIDTH-1:1], accept};
          rem_d   = accept ? sub_result : p_q;
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are decoded from the next state so they register glitch-free.
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
    dv0_d  = (state_d == SUB);
  end

endmodule
